// File: rtl/minisrc_control_unit.sv
// minisrc_control_unit
//   Hardwired control sequencer for the Mini SRC datapath. Runs a fetch
//   sequence (T0-T2), decodes IR[31:27] in T3, then walks the execute steps
//   for register ALU, unary, MUL/DIV, nop and halt instructions.
//
// Ports
//   Clock, Reset_n             : clock, asynchronous active-low reset
//   IR[31:0]                   : instruction register (opcode in IR[31:27])
//   MemRdy                     : memory read complete, only looked at in T1
//   Stop                       : halt request, honoured when an instruction retires
//   Run, Illegal               : running status, sticky undefined-opcode flag
//   PCout..MDRout, Rout        : bus drive enables
//   MARin..HIin, Rin           : register load enables
//   Read, IncPC                : memory read strobe, PC+1 in the ALU
//   Gra, Grb, Grc              : register field select
//   ADD..NOT                   : one-hot ALU operation select
//
// Outputs are a pure decode of the registered state and the IR, so they only
// move after a Clock edge (or immediately on reset assertion).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | in or just out of reset, all outputs low
// ST_RUN   | sequencing; the one-hot step register holds T0..T6
// ST_HALT  | halted by halt opcode, Stop or undefined opcode; exit by reset

module minisrc_control_unit #(
  parameter int NUM_SLOTS     = 8,
  parameter bit ILLEGAL_HALTS = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        MemRdy,
  input  logic        Stop,
  output logic        Run,
  output logic        Illegal,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        LOin,
  output logic        HIin,
  output logic        Read,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        ROR,
  output logic        ROL,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        MUL,
  output logic        DIV,
  output logic        NEG,
  output logic        NOT
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [NUM_SLOTS-1:0] T0_OH = NUM_SLOTS'(1);
  localparam logic [NUM_SLOTS-1:0] T1_OH = NUM_SLOTS'(1) << 1;
  localparam logic [NUM_SLOTS-1:0] T2_OH = NUM_SLOTS'(1) << 2;
  localparam logic [NUM_SLOTS-1:0] T3_OH = NUM_SLOTS'(1) << 3;
  localparam logic [NUM_SLOTS-1:0] T4_OH = NUM_SLOTS'(1) << 4;
  localparam logic [NUM_SLOTS-1:0] T5_OH = NUM_SLOTS'(1) << 5;
  localparam logic [NUM_SLOTS-1:0] T6_OH = NUM_SLOTS'(1) << 6;

  logic [1:0]           state, state_nxt;
  logic [NUM_SLOTS-1:0] step, step_nxt;
  logic                 t1_seen, t1_seen_nxt;     // PCin already pulsed in this T1
  logic                 stop_req, stop_req_nxt;   // Stop seen during current instruction
  logic                 illegal_q, illegal_nxt;
  logic                 last_step;

  logic [4:0] opcode;
  logic       is_alu, is_muldiv, is_unary, is_nop, is_halt, is_undef, as_nop;

  // Operand fields and spare step slots are decoded by the datapath, not here.
  logic unused_bits;
  assign unused_bits = ^{IR[26:0], step[NUM_SLOTS-1:7]};

  assign opcode = IR[31:27];

  always_comb begin
    is_alu    = (opcode >= 5'd3) && (opcode <= 5'd11);
    is_muldiv = (opcode == 5'd15) || (opcode == 5'd16);
    is_unary  = (opcode == 5'd17) || (opcode == 5'd18);
    is_nop    = (opcode == 5'd26);
    is_halt   = (opcode == 5'd27);
    is_undef  = !(is_alu || is_muldiv || is_unary || is_nop || is_halt);
    as_nop    = is_nop || (is_undef && !ILLEGAL_HALTS);
  end

  always_comb begin
    state_nxt    = state;
    step_nxt     = step;
    t1_seen_nxt  = t1_seen;
    stop_req_nxt = stop_req;
    illegal_nxt  = illegal_q;
    last_step    = 1'b0;
    case (state)
      ST_RESET: begin
        state_nxt    = ST_RUN;
        step_nxt     = T0_OH;
        t1_seen_nxt  = 1'b0;
        stop_req_nxt = 1'b0;
      end
      ST_RUN: begin
        // A Stop pulse anywhere inside an instruction is remembered and acted
        // on only when that instruction retires.
        stop_req_nxt = stop_req || Stop;
        if (step[0]) begin
          step_nxt    = T1_OH;
          t1_seen_nxt = 1'b0;
        end else if (step[1]) begin
          t1_seen_nxt = 1'b1;
          if (MemRdy) step_nxt = T2_OH;
        end else if (step[2]) begin
          step_nxt = T3_OH;
        end else if (step[3]) begin
          if (is_alu || is_muldiv || is_unary) begin
            step_nxt = T4_OH;
          end else if (is_halt) begin
            state_nxt = ST_HALT;
          end else if (as_nop) begin
            last_step = 1'b1;
          end else begin
            illegal_nxt = 1'b1;
            state_nxt   = ST_HALT;
          end
        end else if (step[4]) begin
          if (is_alu || is_muldiv) step_nxt = T5_OH;
          else                     last_step = 1'b1;
        end else if (step[5]) begin
          if (is_muldiv) step_nxt = T6_OH;
          else           last_step = 1'b1;
        end else if (step[6]) begin
          last_step = 1'b1;
        end else begin
          step_nxt = T0_OH;   // recover from a corrupted step register
        end
        if (last_step) begin
          stop_req_nxt = 1'b0;
          if (Stop || stop_req) state_nxt = ST_HALT;
          else                  step_nxt  = T0_OH;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_RESET;
      step      <= '0;
      t1_seen   <= 1'b0;
      stop_req  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      t1_seen   <= t1_seen_nxt;
      stop_req  <= stop_req_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  always_comb begin
    Run = (state == ST_RUN);
    Illegal = illegal_q;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; LOin = 1'b0; HIin = 1'b0;
    Read = 1'b0; IncPC = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0; ROR = 1'b0; ROL = 1'b0;
    SHR = 1'b0; SHRA = 1'b0; SHL = 1'b0; MUL = 1'b0; DIV = 1'b0;
    NEG = 1'b0; NOT = 1'b0;
    if (state == ST_RUN) begin
      if (step[0]) begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end else if (step[1]) begin
        // Zlowout stays on while waiting so the bus never floats; only the
        // PC load is limited to the first T1 cycle.
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin    = !t1_seen;
      end else if (step[2]) begin
        MDRout = 1'b1; IRin = 1'b1;
      end else if (step[3]) begin
        if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
          NEG = (opcode == 5'd17);
          NOT = (opcode == 5'd18);
        end
      end else if (step[4]) begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
          ADD  = (opcode == 5'd3);
          SUB  = (opcode == 5'd4);
          AND  = (opcode == 5'd5);
          OR   = (opcode == 5'd6);
          ROR  = (opcode == 5'd7);
          ROL  = (opcode == 5'd8);
          SHR  = (opcode == 5'd9);
          SHRA = (opcode == 5'd10);
          SHL  = (opcode == 5'd11);
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
          MUL = (opcode == 5'd15);
          DIV = (opcode == 5'd16);
        end else if (is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end else if (step[5]) begin
        if (is_alu) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end
      end else if (step[6]) begin
        if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Testbench for minisrc_control_unit: directed and random instructions, each
// expanded by a reference model into its expected per-cycle control word.

module tb_minisrc_control_unit;

  logic        Clock, Reset_n, MemRdy, Stop;
  logic [31:0] IR;
  logic Run, Illegal, PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, LOin, HIin, Read, IncPC, Gra, Grb, Grc, Rin, Rout;
  logic ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT;

  minisrc_control_unit #(.NUM_SLOTS(8), .ILLEGAL_HALTS(1'b1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .MemRdy(MemRdy), .Stop(Stop),
    .Run(Run), .Illegal(Illegal), .PCout(PCout), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin),
    .Read(Read), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .ROR(ROR), .ROL(ROL),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam int B_RUN = 33, B_ILL = 32, B_PCOUT = 31, B_ZLO = 30, B_ZHI = 29;
  localparam int B_MDROUT = 28, B_MARIN = 27, B_PCIN = 26, B_MDRIN = 25, B_IRIN = 24;
  localparam int B_YIN = 23, B_ZIN = 22, B_LOIN = 21, B_HIIN = 20, B_READ = 19;
  localparam int B_INCPC = 18, B_GRA = 17, B_GRB = 16, B_GRC = 15, B_RIN = 14;
  localparam int B_ROUT = 13;

  logic [33:0] obs;
  assign obs = {Run, Illegal, PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin,
                IRin, Yin, Zin, LOin, HIin, Read, IncPC, Gra, Grb, Grc, Rin, Rout,
                ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT};

  int vectors = 0;
  int miscompares = 0;
  bit ill_model = 1'b0;

  function automatic logic [33:0] m(input int b);
    return 34'(1) << b;
  endfunction

  // ALU strobe position: ADD..SHL occupy bits 12..4, MUL/DIV/NEG/NOT bits 3..0.
  function automatic logic [33:0] op_strobe(input logic [4:0] op);
    int o;
    o = int'(op);
    if (o >= 3 && o <= 11) return m(15 - o);
    if (o >= 15 && o <= 18) return m(18 - o);
    return '0;
  endfunction

  task automatic check(input string tag, input logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    Stop    = 1'b0;
    MemRdy  = 1'b1;
    #1;
    check({tag, "_async"}, '0);
    @(negedge Clock);
    @(negedge Clock);
    check({tag, "_held"}, '0);
    ill_model = 1'b0;
    Reset_n   = 1'b1;
  endtask

  task automatic check_halted(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      check($sformatf("%s_halt%0d", tag, i), ill_model ? m(B_ILL) : 34'd0);
      Stop = 1'b0;
    end
  endtask

  // stop_at / abort_at: cycle index (0 = T0) at which to pulse Stop or to
  // drop Reset_n mid-cycle; -1 disables.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int waits,
                           input int stop_at, input int abort_at);
    logic [33:0] q[$];
    logic [33:0] r;
    logic [4:0]  op;
    int          o;
    bit          halts;
    op = ir[31:27];
    o  = int'(op);
    r  = m(B_RUN);
    q.push_back(r | m(B_PCOUT) | m(B_MARIN) | m(B_INCPC) | m(B_ZIN));
    q.push_back(r | m(B_ZLO) | m(B_PCIN) | m(B_READ) | m(B_MDRIN));
    for (int w = 0; w < waits; w++) q.push_back(r | m(B_ZLO) | m(B_READ) | m(B_MDRIN));
    q.push_back(r | m(B_MDROUT) | m(B_IRIN));
    halts = (stop_at >= 0);
    if (o >= 3 && o <= 11) begin
      q.push_back(r | m(B_GRB) | m(B_ROUT) | m(B_YIN));
      q.push_back(r | m(B_GRC) | m(B_ROUT) | op_strobe(op) | m(B_ZIN));
      q.push_back(r | m(B_ZLO) | m(B_GRA) | m(B_RIN));
    end else if (o == 15 || o == 16) begin
      q.push_back(r | m(B_GRA) | m(B_ROUT) | m(B_YIN));
      q.push_back(r | m(B_GRB) | m(B_ROUT) | op_strobe(op) | m(B_ZIN));
      q.push_back(r | m(B_ZLO) | m(B_LOIN));
      q.push_back(r | m(B_ZHI) | m(B_HIIN));
    end else if (o == 17 || o == 18) begin
      q.push_back(r | m(B_GRB) | m(B_ROUT) | op_strobe(op) | m(B_ZIN));
      q.push_back(r | m(B_ZLO) | m(B_GRA) | m(B_RIN));
    end else begin
      q.push_back(r);
      if (o == 27) halts = 1'b1;
      else if (o != 26) halts = 1'b1;   // undefined opcode halts in this build
    end
    for (int k = 0; k < q.size(); k++) begin
      @(negedge Clock);
      check($sformatf("%s_c%0d", tag, k), q[k]);
      if (k == 0) IR = ir;
      MemRdy = !(k >= 1 && k <= waits);
      Stop   = (k == stop_at);
      if (k == abort_at) begin
        #2;
        Reset_n = 1'b0;
        #1;
        check({tag, "_abort"}, '0);
        Stop   = 1'b0;
        MemRdy = 1'b1;
        return;
      end
    end
    if (halts) begin
      if (!(o == 27 || (o >= 3 && o <= 11) || (o >= 15 && o <= 18) || o == 26))
        ill_model = 1'b1;
      check_halted(tag, 3);
    end
  endtask

  int legal_ops[14] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 26};

  initial begin
    Reset_n = 1'b1;
    MemRdy  = 1'b1;
    Stop    = 1'b0;
    IR      = 32'h0;
    #2;
    do_reset("por");

    run_instr("add",  32'h1A2B8000, 0, -1, -1);
    run_instr("neg",  32'h8A800000, 0, -1, -1);
    run_instr("not",  32'h92800000, 0, -1, -1);
    run_instr("mul",  32'h7A000000, 0, -1, -1);
    run_instr("div",  32'h82000000, 1, -1, -1);
    run_instr("add_wait", 32'h1A2B8000, 3, -1, -1);
    run_instr("nop",  32'hD0000000, 0, -1, -1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ir;
      int          op;
      op = legal_ops[$urandom_range(0, 13)];
      ir = {5'(op), 27'($urandom)};
      run_instr($sformatf("rnd%0d", i), ir, int'($urandom_range(0, 3)), -1, -1);
    end

    run_instr("stop_fetch", 32'hD0000000, 0, 1, -1);
    do_reset("rst1");
    run_instr("stop_and", 32'h2A2B8000, 0, 4, -1);
    do_reset("rst2");
    run_instr("illegal", 32'hF8000000, 0, -1, -1);
    do_reset("rst3");
    run_instr("add_abort", 32'h1A2B8000, 0, -1, 4);
    do_reset("rst4");
    run_instr("add_after", 32'h1A2B8000, 0, -1, -1);
    run_instr("halt", 32'hD8000000, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
